// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the IF stage of the P5 five-stage MIPS core.
//   br_type_e   : ID-stage branch/jump class driven by the decoder
//   PC_RESET    : first fetch address (start of instruction memory)
//   PC_MASK_HI  : number of upper PC+4 bits kept in a j/jal target
//   NOP         : instruction word loaded into IF/ID on reset
package fetch_pc_unit_pkg;

  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_BEQ   = 3'd1,
    BR_BNE   = 3'd2,
    BR_BGTZ  = 3'd3,
    BR_BLTZ  = 3'd4,
    BR_BOVAL = 3'd5,
    BR_J     = 3'd6,
    BR_JR    = 3'd7
  } br_type_e;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam int unsigned PC_MASK_HI = 4;
  localparam logic [31:0] NOP        = '0;

  // Branch offset: sign-extended 16-bit word offset turned into a byte offset.
  function automatic logic [31:0] branchOffset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Bundle between the IF stage and the rest of the core.
//   master : core side (IM read data, ID decode fields, comparator flags)
//   slave  : fetch_pc_unit (PC, IF/ID registers, redirect and link flags)
interface fetch_pc_unit_if;
  import fetch_pc_unit_pkg::*;

  logic [31:0] im_instr;
  br_type_e    br_type;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] jr_target;
  logic        cmp_zero;
  logic        cmp_gtz;
  logic        cmp_ltz;
  logic        cmp_check;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        br_taken;
  logic        link_cond;

  modport master (
    output im_instr, br_type, imm16, instr_index, jr_target,
           cmp_zero, cmp_gtz, cmp_ltz, cmp_check,
    input  pc, id_instr, id_pc, br_taken, link_cond
  );

  modport slave (
    input  im_instr, br_type, imm16, instr_index, jr_target,
           cmp_zero, cmp_gtz, cmp_ltz, cmp_check,
    output pc, id_instr, id_pc, br_taken, link_cond
  );
endinterface

// File: rtl/fetch_pc_unit_npc_calc.sv
// Combinational next-PC selection.
//   brType/cmp*   : ID branch class and comparator flags -> brTaken, linkCond
//   idPc          : PC of the instruction in ID (redirect base)
//   pc            : current IF PC (sequential base)
//   imm16, instrIndex, jrTarget : target fields
//   nextPc        : value the PC register loads on the next unstalled edge
module npc_calc
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned PC_MASK_HI = fetch_pc_unit_pkg::PC_MASK_HI
) (
  input  br_type_e    brType,
  input  logic        cmpZero,
  input  logic        cmpGtz,
  input  logic        cmpLtz,
  input  logic        cmpCheck,
  input  logic [31:0] idPc,
  input  logic [31:0] pc,
  input  logic [15:0] imm16,
  input  logic [25:0] instrIndex,
  input  logic [31:0] jrTarget,
  output logic [31:0] nextPc,
  output logic        brTaken,
  output logic        linkCond
);

  localparam logic [31:0] HI_MASK = ~(32'hFFFF_FFFF >> PC_MASK_HI);

  logic [31:0] idPcPlus4;
  logic [31:0] brTarget;
  logic [31:0] jTarget;
  logic [31:0] target;

  // Targets are relative to the ID instruction, not to the IF PC.
  assign idPcPlus4 = idPc + 32'd4;
  assign brTarget  = idPcPlus4 + branchOffset(imm16);
  assign jTarget   = (idPcPlus4 & HI_MASK) | ({4'b0000, instrIndex, 2'b00} & ~HI_MASK);

  always_comb begin
    brTaken  = 1'b0;
    linkCond = 1'b0;
    target   = brTarget;
    unique case (brType)
      BR_BEQ:   brTaken = cmpZero;
      BR_BNE:   brTaken = !cmpZero;
      BR_BGTZ:  brTaken = cmpGtz;
      BR_BLTZ:  brTaken = cmpLtz;
      BR_BOVAL: begin
        brTaken  = cmpCheck;
        linkCond = cmpCheck;
      end
      BR_J: begin
        brTaken = 1'b1;
        target  = jTarget;
      end
      BR_JR: begin
        brTaken = 1'b1;
        target  = jrTarget;
      end
      default: brTaken = 1'b0;
    endcase
  end

  assign nextPc = brTaken ? target : pc + 32'd4;

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage PC register and IF/ID pipeline register (delay-slot, no flush).
//   clk, reset : single clock, synchronous active-high reset (wins over stall)
//   stall      : hold PC and IF/ID when 1
//   bus        : fetch_pc_unit_if.slave -- IM data, ID fields, comparator
//                flags in; pc, id_instr, id_pc, br_taken, link_cond out
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = fetch_pc_unit_pkg::PC_RESET,
  parameter int unsigned PC_MASK_HI = fetch_pc_unit_pkg::PC_MASK_HI
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  fetch_pc_unit_if.slave    bus
);

  logic [31:0] pcReg;
  logic [31:0] idInstrReg;
  logic [31:0] idPcReg;
  logic [31:0] nextPc;
  logic        brTaken;
  logic        linkCond;

  npc_calc #(.PC_MASK_HI(PC_MASK_HI)) uNpcCalc (
    .brType     (bus.br_type),
    .cmpZero    (bus.cmp_zero),
    .cmpGtz     (bus.cmp_gtz),
    .cmpLtz     (bus.cmp_ltz),
    .cmpCheck   (bus.cmp_check),
    .idPc       (idPcReg),
    .pc         (pcReg),
    .imm16      (bus.imm16),
    .instrIndex (bus.instr_index),
    .jrTarget   (bus.jr_target),
    .nextPc     (nextPc),
    .brTaken    (brTaken),
    .linkCond   (linkCond)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg      <= PC_RESET;
      idInstrReg <= NOP;
      idPcReg    <= PC_RESET;
    end else if (!stall) begin
      pcReg      <= nextPc;
      idInstrReg <= bus.im_instr;
      idPcReg    <= pcReg;
    end
  end

  assign bus.pc        = pcReg;
  assign bus.id_instr  = idInstrReg;
  assign bus.id_pc     = idPcReg;
  assign bus.br_taken  = brTaken;
  assign bus.link_cond = linkCond;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;
  import fetch_pc_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic stall;
  int   nChecks = 0;
  int   nFails  = 0;

  fetch_pc_unit_if bus();

  fetch_pc_unit #(.PC_RESET(32'h0000_3000), .PC_MASK_HI(4)) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory model: a distinct, non-zero word per address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign bus.im_instr = imem(bus.pc);

  task automatic setIdle();
    bus.br_type     = BR_NONE;
    bus.imm16       = '0;
    bus.instr_index = '0;
    bus.jr_target   = '0;
    bus.cmp_zero    = 1'b0;
    bus.cmp_gtz     = 1'b0;
    bus.cmp_ltz     = 1'b0;
    bus.cmp_check   = 1'b0;
  endtask

  // Advance one edge; return 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves pc = id_pc = 0x3000, id_instr = 0, inputs idle.
  task automatic doReset();
    reset = 1'b1;
    stall = 1'b0;
    setIdle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b0;
    setIdle();
    tick();
    tick();
    nChecks++; if (bus.pc !== 32'h3000) begin nFails++; $display("FAIL reset_pc: got %h expected %h", bus.pc, 32'h3000); end
    nChecks++; if (bus.id_instr !== 32'h0) begin nFails++; $display("FAIL reset_id_instr: got %h expected %h", bus.id_instr, 32'h0); end
    nChecks++; if (bus.id_pc !== 32'h3000) begin nFails++; $display("FAIL reset_id_pc: got %h expected %h", bus.id_pc, 32'h3000); end
    nChecks++; if (bus.br_taken !== 1'b0) begin nFails++; $display("FAIL reset_br_taken: got %b expected 0", bus.br_taken); end
    reset = 1'b0;
    tick();
    nChecks++; if (bus.pc !== 32'h3004) begin nFails++; $display("FAIL seq1_pc: got %h expected %h", bus.pc, 32'h3004); end
    nChecks++; if (bus.id_pc !== 32'h3000) begin nFails++; $display("FAIL seq1_id_pc: got %h expected %h", bus.id_pc, 32'h3000); end
    nChecks++; if (bus.id_instr !== imem(32'h3000)) begin nFails++; $display("FAIL seq1_id_instr: got %h expected %h", bus.id_instr, imem(32'h3000)); end
    tick();
    nChecks++; if (bus.pc !== 32'h3008) begin nFails++; $display("FAIL seq2_pc: got %h expected %h", bus.pc, 32'h3008); end
    nChecks++; if (bus.id_pc !== 32'h3004) begin nFails++; $display("FAIL seq2_id_pc: got %h expected %h", bus.id_pc, 32'h3004); end
    nChecks++; if (bus.id_instr !== imem(32'h3004)) begin nFails++; $display("FAIL seq2_id_instr: got %h expected %h", bus.id_instr, imem(32'h3004)); end
  endtask

  task automatic test_beq();
    // Taken: id_pc=0x3004, offset -8 -> 0x3000.
    doReset();
    tick();
    tick();
    bus.br_type  = BR_BEQ;
    bus.imm16    = 16'hFFFE;
    bus.cmp_zero = 1'b1;
    #1;
    nChecks++; if (bus.br_taken !== 1'b1) begin nFails++; $display("FAIL beq_taken_flag: got %b expected 1", bus.br_taken); end
    nChecks++; if (bus.link_cond !== 1'b0) begin nFails++; $display("FAIL beq_link_cond: got %b expected 0", bus.link_cond); end
    tick();
    setIdle();
    nChecks++; if (bus.pc !== 32'h3000) begin nFails++; $display("FAIL beq_taken_pc: got %h expected %h", bus.pc, 32'h3000); end
    nChecks++; if (bus.id_pc !== 32'h3008) begin nFails++; $display("FAIL beq_slot_id_pc: got %h expected %h", bus.id_pc, 32'h3008); end
    nChecks++; if (bus.id_instr !== imem(32'h3008)) begin nFails++; $display("FAIL beq_slot_id_instr: got %h expected %h", bus.id_instr, imem(32'h3008)); end
    // Not taken: falls through to pc+4.
    doReset();
    tick();
    tick();
    bus.br_type  = BR_BEQ;
    bus.imm16    = 16'hFFFE;
    bus.cmp_zero = 1'b0;
    #1;
    nChecks++; if (bus.br_taken !== 1'b0) begin nFails++; $display("FAIL beq_nt_flag: got %b expected 0", bus.br_taken); end
    tick();
    setIdle();
    nChecks++; if (bus.pc !== 32'h300C) begin nFails++; $display("FAIL beq_nt_pc: got %h expected %h", bus.pc, 32'h300C); end
  endtask

  task automatic test_boval();
    // id_pc=0x3010, imm 4 -> 0x3014 + 0x10 = 0x3024.
    doReset();
    for (int i = 0; i < 5; i++) tick();
    bus.br_type   = BR_BOVAL;
    bus.imm16     = 16'h0004;
    bus.cmp_check = 1'b0;
    #1;
    nChecks++; if (bus.br_taken !== 1'b0) begin nFails++; $display("FAIL boval_nt_flag: got %b expected 0", bus.br_taken); end
    nChecks++; if (bus.link_cond !== 1'b0) begin nFails++; $display("FAIL boval_nt_link: got %b expected 0", bus.link_cond); end
    bus.cmp_check = 1'b1;
    #1;
    nChecks++; if (bus.br_taken !== 1'b1) begin nFails++; $display("FAIL boval_taken_flag: got %b expected 1", bus.br_taken); end
    nChecks++; if (bus.link_cond !== 1'b1) begin nFails++; $display("FAIL boval_link: got %b expected 1", bus.link_cond); end
    tick();
    setIdle();
    nChecks++; if (bus.pc !== 32'h3024) begin nFails++; $display("FAIL boval_pc: got %h expected %h", bus.pc, 32'h3024); end
    // Overflow flag must not raise link_cond for other branch types.
    bus.br_type   = BR_BEQ;
    bus.cmp_check = 1'b1;
    #1;
    nChecks++; if (bus.link_cond !== 1'b0) begin nFails++; $display("FAIL beq_check_link: got %b expected 0", bus.link_cond); end
    setIdle();
  endtask

  task automatic test_stall();
    // pc=0x3008, id_pc=0x3004; BGTZ imm 0x10 -> 0x3008 + 0x40 = 0x3048.
    doReset();
    tick();
    tick();
    stall       = 1'b1;
    bus.br_type = BR_BGTZ;
    bus.imm16   = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      bus.cmp_gtz = (i % 2 == 0);
      #1;
      nChecks++; if (bus.br_taken !== bus.cmp_gtz) begin nFails++; $display("FAIL stall_br_taken[%0d]: got %b expected %b", i, bus.br_taken, bus.cmp_gtz); end
      tick();
      nChecks++; if (bus.pc !== 32'h3008) begin nFails++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, bus.pc, 32'h3008); end
      nChecks++; if (bus.id_pc !== 32'h3004) begin nFails++; $display("FAIL stall_id_pc[%0d]: got %h expected %h", i, bus.id_pc, 32'h3004); end
      nChecks++; if (bus.id_instr !== imem(32'h3004)) begin nFails++; $display("FAIL stall_id_instr[%0d]: got %h expected %h", i, bus.id_instr, imem(32'h3004)); end
    end
    stall       = 1'b0;
    bus.cmp_gtz = 1'b1;
    tick();
    setIdle();
    nChecks++; if (bus.pc !== 32'h3048) begin nFails++; $display("FAIL unstall_pc: got %h expected %h", bus.pc, 32'h3048); end
    nChecks++; if (bus.id_pc !== 32'h3008) begin nFails++; $display("FAIL unstall_id_pc: got %h expected %h", bus.id_pc, 32'h3008); end
    nChecks++; if (bus.id_instr !== imem(32'h3008)) begin nFails++; $display("FAIL unstall_id_instr: got %h expected %h", bus.id_instr, imem(32'h3008)); end
  endtask

  task automatic test_jump();
    doReset();
    // Use JR to place 0x3FFC in IF, then let it move into ID.
    bus.br_type   = BR_JR;
    bus.jr_target = 32'h0000_3FFC;
    tick();
    setIdle();
    nChecks++; if (bus.pc !== 32'h3FFC) begin nFails++; $display("FAIL jr_setup_pc: got %h expected %h", bus.pc, 32'h3FFC); end
    tick();
    nChecks++; if (bus.id_pc !== 32'h3FFC) begin nFails++; $display("FAIL j_setup_id_pc: got %h expected %h", bus.id_pc, 32'h3FFC); end
    // J: upper bits of id_pc+4 (0x4000) are 0, index 0xC10 -> 0x3040.
    bus.br_type     = BR_J;
    bus.instr_index = 26'h0000C10;
    #1;
    nChecks++; if (bus.br_taken !== 1'b1) begin nFails++; $display("FAIL j_flag: got %b expected 1", bus.br_taken); end
    tick();
    setIdle();
    nChecks++; if (bus.pc !== 32'h3040) begin nFails++; $display("FAIL j_pc: got %h expected %h", bus.pc, 32'h3040); end
    // J keeps the upper nibble of id_pc+4: id_pc=0x3FFC is not enough, so
    // jump to a high region with JR first.
    bus.br_type   = BR_JR;
    bus.jr_target = 32'hA000_0010;
    tick();
    setIdle();
    tick();
    bus.br_type     = BR_J;
    bus.instr_index = 26'h3FF_FFFF;
    tick();
    setIdle();
    nChecks++; if (bus.pc !== 32'hAFFF_FFFC) begin nFails++; $display("FAIL j_hi_pc: got %h expected %h", bus.pc, 32'hAFFF_FFFC); end
    // JR to the top of the address space, then sequential wrap.
    bus.br_type   = BR_JR;
    bus.jr_target = 32'hFFFF_FFFC;
    tick();
    setIdle();
    nChecks++; if (bus.pc !== 32'hFFFF_FFFC) begin nFails++; $display("FAIL jr_pc: got %h expected %h", bus.pc, 32'hFFFF_FFFC); end
    tick();
    nChecks++; if (bus.pc !== 32'h0000_0000) begin nFails++; $display("FAIL wrap_pc: got %h expected %h", bus.pc, 32'h0); end
    nChecks++; if (bus.id_pc !== 32'hFFFF_FFFC) begin nFails++; $display("FAIL wrap_id_pc: got %h expected %h", bus.id_pc, 32'hFFFF_FFFC); end
  endtask

  task automatic test_blt_back_to_back();
    // pc=0x3008, id_pc=0x3004; BLTZ imm 0x10 -> 0x3048.
    doReset();
    tick();
    tick();
    bus.br_type = BR_BLTZ;
    bus.imm16   = 16'h0010;
    bus.cmp_ltz = 1'b1;
    tick();
    setIdle();
    nChecks++; if (bus.pc !== 32'h3048) begin nFails++; $display("FAIL b2b_first_pc: got %h expected %h", bus.pc, 32'h3048); end
    // Slot (id_pc=0x3008) is itself a taken BNE, imm 2 -> 0x300C + 8 = 0x3014.
    bus.br_type  = BR_BNE;
    bus.imm16    = 16'h0002;
    bus.cmp_zero = 1'b0;
    tick();
    setIdle();
    nChecks++; if (bus.pc !== 32'h3014) begin nFails++; $display("FAIL b2b_second_pc: got %h expected %h", bus.pc, 32'h3014); end
    nChecks++; if (bus.id_pc !== 32'h3048) begin nFails++; $display("FAIL b2b_second_id_pc: got %h expected %h", bus.id_pc, 32'h3048); end
  endtask

  task automatic test_reset_priority();
    doReset();
    tick();
    tick();
    stall        = 1'b1;
    bus.br_type  = BR_BNE;
    bus.imm16    = 16'h0040;
    bus.cmp_zero = 1'b0;
    #1;
    nChecks++; if (bus.br_taken !== 1'b1) begin nFails++; $display("FAIL rstpri_flag: got %b expected 1", bus.br_taken); end
    reset = 1'b1;
    tick();
    nChecks++; if (bus.pc !== 32'h3000) begin nFails++; $display("FAIL rstpri_pc: got %h expected %h", bus.pc, 32'h3000); end
    nChecks++; if (bus.id_instr !== 32'h0) begin nFails++; $display("FAIL rstpri_id_instr: got %h expected %h", bus.id_instr, 32'h0); end
    nChecks++; if (bus.id_pc !== 32'h3000) begin nFails++; $display("FAIL rstpri_id_pc: got %h expected %h", bus.id_pc, 32'h3000); end
    reset = 1'b0;
    stall = 1'b0;
    setIdle();
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    setIdle();
    test_reset();
    test_beq();
    test_boval();
    test_stall();
    test_jump();
    test_blt_back_to_back();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
